// File: rtl/mdu_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  // Operation codes presented on the op port; codes 6 and 7 are unused.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // Control states of the iterative engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Number of shift-add / restoring steps per operation.
  localparam int unsigned MDU_ITER = 32;

  // Quotient delivered on divide by zero.
  localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_hilo_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0]   trial_s;
  logic [W-1:0] diff_s;

  assign trial_s = {rem_i, bit_i};
  // When the subtraction is taken the result is below the divisor, so W bits suffice.
  assign diff_s  = trial_s[W-1:0] - divisor_i;

  // Choose between the restored and the reduced remainder.
  always_comb begin
    rem_o  = trial_s[W-1:0];
    qbit_o = 1'b0;
    if (trial_s >= {1'b0, divisor_i}) begin
      rem_o  = diff_s;
      qbit_o = 1'b1;
    end else begin
      rem_o  = trial_s[W-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, processed for MDU_ITER
// steps in RUN, and sign-corrected/special-cased in FIX.
// Optional build macro MDU_FAST_MULT_EN: MULT/MULTU form the 64-bit product in
// one cycle and go straight from IDLE to FIX; division is unaffected.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]     acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]       opb_q, opb_d;
  // Raw rs kept for the divide-by-zero remainder.
  logic [XLEN-1:0]       rs_q, rs_d;
  logic                  is_div_q, is_div_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  div0_q, div0_d;
  logic                  ovf_q, ovf_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  signed_op_s;
  logic [XLEN-1:0]       mag_rs_s, mag_rt_s;
  logic [XLEN:0]         mul_sum_s;
  logic [2*XLEN-1:0]     acc_neg_s;
  logic [XLEN-1:0]       lo_neg_s, hi_neg_s;
  logic [XLEN-1:0]       step_rem_s;
  logic                  step_qbit_s;

  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MDU_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  assign signed_op_s = (op == MDU_MULT) || (op == MDU_DIV);
  assign mag_rs_s    = (signed_op_s && rs_data[XLEN-1]) ? ({XLEN{1'b0}} - rs_data) : rs_data;
  assign mag_rt_s    = (signed_op_s && rt_data[XLEN-1]) ? ({XLEN{1'b0}} - rt_data) : rt_data;

  // Shift-add: add the multiplicand into the upper half when the current multiplier bit is set.
  assign mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});

  assign acc_neg_s = {(2*XLEN){1'b0}} - acc_q;
  assign lo_neg_s  = {XLEN{1'b0}} - acc_q[XLEN-1:0];
  assign hi_neg_s  = {XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN];

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .bit_i     (acc_q[XLEN-1]),
    .divisor_i (opb_q),
    .rem_o     (step_rem_s),
    .qbit_o    (step_qbit_s)
  );

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    rs_d     = rs_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              is_div_d = 1'b0;
              qneg_d   = signed_op_s & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
              rneg_d   = 1'b0;
              div0_d   = 1'b0;
              ovf_d    = 1'b0;
              rs_d     = rs_data;
              opb_d    = mag_rs_s;
              cnt_d    = {CNT_W{1'b0}};
`ifdef MDU_FAST_MULT_EN
              acc_d    = {{XLEN{1'b0}}, mag_rs_s} * {{XLEN{1'b0}}, mag_rt_s};
              state_d  = FIX;
`else
              acc_d    = {{XLEN{1'b0}}, mag_rt_s};
              state_d  = RUN;
`endif
            end
            MDU_DIV, MDU_DIVU: begin
              is_div_d = 1'b1;
              qneg_d   = signed_op_s & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
              rneg_d   = signed_op_s & rs_data[XLEN-1];
              div0_d   = (rt_data == {XLEN{1'b0}});
              ovf_d    = (op == MDU_DIV) && (rs_data == INT_MIN) && (rt_data == ALL_ONES);
              rs_d     = rs_data;
              opb_d    = mag_rt_s;
              acc_d    = {{XLEN{1'b0}}, mag_rs_s};
              cnt_d    = {CNT_W{1'b0}};
              state_d  = RUN;
            end
            MDU_MTHI: begin
              hi_d = rs_data;
            end
            MDU_MTLO: begin
              lo_d = rs_data;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (is_div_q) begin
          acc_d = {step_rem_s, acc_q[XLEN-2:0], step_qbit_s};
        end else begin
          acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        if (is_div_q) begin
          if (div0_q) begin
            lo_d = MDU_DIV0_Q;
            hi_d = rs_q;
          end else if (ovf_q) begin
            lo_d = INT_MIN;
            hi_d = {XLEN{1'b0}};
          end else begin
            lo_d = qneg_q ? lo_neg_s : acc_q[XLEN-1:0];
            hi_d = rneg_q ? hi_neg_s : acc_q[2*XLEN-1:XLEN];
          end
        end else begin
          {hi_d, lo_d} = qneg_q ? acc_neg_s : acc_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      opb_q    <= {XLEN{1'b0}};
      rs_q     <= {XLEN{1'b0}};
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      rs_q     <= rs_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file: it consumes read_data1 (rs) and read_data2 (rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- HI/LO are exposed so MFHI/MFLO results can be muxed onto the register-file write_data path.
- busy stalls the pipeline for any HI/LO access while an operation is in flight.

Parameters:
- XLEN, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request; sampled on the rising edge when busy=0
- op  in  3  operation code (mdu_op_e)
- rs_data  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source
- rt_data  in  32  operand B: multiplier or divisor
- busy  out  1  high while state!=IDLE
- done  out  1  registered one-cycle pulse marking completion of a MULT/DIV
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset asserted mid-operation aborts the operation immediately; HI/LO clear to 0.
- States:
  - IDLE: accepts start.
  - RUN: performs XLEN iterations.
  - FIX: applies sign correction and special cases, then writes HI/LO.
- start when busy=1 is ignored, with no side effects.
- op values 6 and 7 are ignored; the unit stays in IDLE.
- MTHI / MTLO: accepted in IDLE. hi (or lo) <= rs_data at that same edge. No busy, no done.
- MULT / MULTU, start accepted at edge N:
  - Operands are latched as magnitudes; the result-negative flag is recorded for the signed op.
  - RUN covers edges N+1..N+32, one shift-add step per edge.
  - FIX occurs at edge N+33: {hi,lo} <= the 64-bit product, 2's-complement negated if the flag is set. state->IDLE.
  - busy is high for cycles N+1..N+33.
  - done is high for the single cycle following edge N+33.
- DIV / DIVU:
  - Same timing as multiply.
  - Restoring division, one quotient bit per RUN edge, on magnitudes.
  - FIX: lo <= quotient, hi <= remainder. For DIV the quotient sign is rs^rt; the remainder takes the sign of rs.
- Divide by zero (rt=0): lo=32'hFFFF_FFFF, hi=rs_data, for both DIV and DIVU. Full latency still applies.
- Signed overflow (DIV, rs=32'h8000_0000, rt=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- HI/LO hold their value during RUN. They change only in FIX, on MTHI/MTLO, or on reset.
- done deasserts the cycle after its pulse.
- A start that coincides with the done cycle is accepted, because busy=0 in that cycle.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 64-bit product.
  - The accepted start at edge N goes IDLE->FIX.
  - hi/lo are updated at edge N+1; busy is high for cycle N+1 only.
  - done is high for the cycle following edge N+1.
  - Division is unchanged.
- Undefined: iterative 33-cycle multiply as described in Behaviour.

Decomposition:
- Package mdu_pkg contains:
  - mdu_op_e (3-bit): MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
  - mdu_state_e: IDLE, RUN, FIX.
  - Constants: MDU_ITER=32, MDU_DIV0_Q=32'hFFFF_FFFF.
- Sub-module mdu_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside the RUN datapath.

Test Plan:
- Reset mid-op: MULTU rs=5, rt=7, then rst_n low at cycle 10 -> hi=lo=0, busy=0, no done pulse.
- MULT rs=32'hFFFF_FFFD (-3), rt=4 -> done in the cycle after edge N+33; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF4. Busy high for exactly 33 cycles.
- MULTU rs=rt=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- Signed division:
  - DIV rs=-7 (32'hFFFF_FFF9), rt=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
  - DIVU rs=100, rt=7 -> lo=14, hi=2.
- Divide special cases:
  - DIVU rs=123, rt=0 -> lo=32'hFFFF_FFFF, hi=123.
  - DIV rs=32'h8000_0000, rt=-1 -> lo=32'h8000_0000, hi=0.
- Handshake: MTHI rs=32'hA5A5_A5A5 -> hi updated the next cycle, no done.
  - MTLO issued while busy -> lo unchanged.
  - Back-to-back start in the done cycle -> second op accepted, busy reasserts the next cycle.
